instr_mem_loader: RTL

- Encoder counterpart to the main/ALU control decoders.
- Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word using exactly the opcode/funct values the control path decodes.
- Writes the words sequentially into the instruction memory of the single-cycle core, so test programs load through RTL rather than a hex file.

---
 rtl/mips_isa_pkg.sv | 37 +++
 rtl/instr_mem_loader_encoder.sv | 34 +++
 rtl/instr_mem_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the loader/encoder and the control decoders.
// Opcode/funct values match what the single-cycle control path decodes.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_mem_loader_encoder.sv
// Combinational encoder: symbolic instruction kind plus fields -> 32-bit MIPS word.
// Kinds 10-15 report legal=0 with a zero word.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    case (kind)
      KIND_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADD};
      KIND_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SUB};
      KIND_AND:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_AND};
      KIND_OR:   word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_OR};
      KIND_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SLT};
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams encoded instructions into instruction memory at consecutive word addresses.
// One-cycle write latency; in_ready drops outside LOAD, when full, or during start/finish.
module instr_mem_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        accept;

  instr_encoder u_enc (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .legal  (enc_legal),
    .word   (enc_word)
  );

  assign in_ready = (state_q == ST_LOAD) && (count_q < FULL) && !start && !finish;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept) begin
      if (enc_legal) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = enc_word;
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // start overrides finish and any other transition; a registered write still drains
    if (start) begin
      state_d = ST_LOAD;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_LOAD && (finish || count_d == FULL)) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_q;

endmodule
